// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 width codes (B/H/W and the unsigned load variants)
//   - FSM state encoding (2 bits)
//   - byte-enable base patterns, plus helper functions for the
//     misalignment test, lane enables and store-data replication.
package load_store_unit_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_WB       = 2'd3
  } state_t;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return (lo != 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_B, F3_BU: return BE_BYTE << lo;
      F3_H, F3_HU: return BE_HALF << lo;
      default:     return BE_WORD;
    endcase
  endfunction

  // The byte/half is copied into every lane so memory only has to
  // honour the byte enables; no shifter is needed on the store path.
  function automatic logic [XLEN-1:0] replicate(input logic [2:0] f3, input logic [XLEN-1:0] wdata);
    case (f3)
      F3_B, F3_BU: return {4{wdata[7:0]}};
      F3_H, F3_HU: return {2{wdata[15:0]}};
      default:     return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: combinational load-data lane extraction and extension.
// Ports:
//   funct3  in  3   load width/sign code
//   addr_lo in  2   byte offset within the word
//   rdata   in  32  raw word from memory
//   data    out 32  extracted, sign/zero-extended value
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    // Bring the addressed lane down to bit 0 first.
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between the
// execute stage and a data memory with request/response handshakes.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             op handshake from execute (ready only in IDLE)
//   req_is_store/funct3/addr/wdata/rd  op fields
//   mem_req_valid/mem_req_ready     memory request handshake
//   mem_we/mem_be/mem_addr/mem_wdata   request fields (word-aligned address)
//   mem_rsp_valid/mem_rdata         response strobe and read word
//   wb_valid/wb_rd/wb_data          register writeback pulse and payload
//   err_misaligned                  one-cycle pulse on misaligned request
//   busy                            high whenever not IDLE
//   state                           current FSM state (debug)
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; the sender keeps valid and its payload stable until
// that edge. The response side has no ready: mem_rsp_valid is a strobe
// that is consumed only in WAIT_RSP and ignored in every other state.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  input  logic [REG_W-1:0] req_rd,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  input  logic             mem_rsp_valid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             wb_valid,
  output logic [REG_W-1:0] wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             err_misaligned,
  output logic             busy,
  output logic [1:0]       state
);

  state_t           state_q, state_d;
  logic             is_store_q;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  wdata_q;
  logic [REG_W-1:0] rd_q;
  logic             err_q;
  logic [REG_W-1:0] wb_rd_q;
  logic [XLEN-1:0]  wb_data_q;
  logic [XLEN-1:0]  load_data;

  logic accept;
  logic req_misaligned;
  logic rsp_take;

  assign accept         = (state_q == ST_IDLE) && req_valid;
  assign req_misaligned = is_misaligned(req_funct3, req_addr[1:0]);
  assign rsp_take       = (state_q == ST_WAIT_RSP) && mem_rsp_valid;

  load_align u_load_align (
    .funct3  (funct3_q),
    .addr_lo (addr_q[1:0]),
    .rdata   (mem_rdata),
    .data    (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    wb_valid      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_misaligned) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (mem_rsp_valid) state_d = is_store_q ? ST_IDLE : ST_WB;
      end
      ST_WB: begin
        // x0 is never written, so no pulse for rd == 0.
        wb_valid = (rd_q != '0);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields are captured on every accepted op, including a
  // misaligned one that is rejected in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
    end else if (accept) begin
      is_store_q <= req_is_store;
      funct3_q   <= req_funct3;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      rd_q       <= req_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept && req_misaligned;
  end

  // Writeback payload only moves when a real pulse will follow, so it
  // holds its last value across stores and rd == 0 loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else if (rsp_take && !is_store_q && (rd_q != '0)) begin
      wb_rd_q   <= rd_q;
      wb_data_q <= load_data;
    end
  end

  assign mem_we         = (state_q == ST_ISSUE) && is_store_q;
  assign mem_be         = (state_q == ST_ISSUE) ? byte_enable(funct3_q, addr_q[1:0]) : 4'b0000;
  assign mem_addr       = {addr_q[XLEN-1:2], 2'b00};
  assign mem_wdata      = replicate(funct3_q, wdata_q);
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign err_misaligned = err_q;
  assign busy           = (state_q != ST_IDLE);
  assign state          = state_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: none; all widths fixed (XLEN 32, register index 5).
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  execute stage presents a memory op.
REQ-005 req_ready  out  1  unit accepts op; high only in IDLE.
REQ-006 req_is_store  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 only for stores.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, LSB-justified.
REQ-010 req_rd  in  5  load destination register.
REQ-011 mem_req_valid  out  1  request to data memory.
REQ-012 mem_req_ready  in  1  memory accepts request.
REQ-013 mem_we / mem_be / mem_addr / mem_wdata  out  1/4/32/32  write enable, byte lanes, word-aligned address (addr[1:0]=00), lane-shifted data.
REQ-014 mem_rsp_valid / mem_rdata  in  1/32  response strobe (load data or store ack) and read word.
REQ-015 wb_valid / wb_rd / wb_data  out  1/5/32  writeback to register file: one-cycle pulse, index, value.
REQ-016 err_misaligned  out  1  one-cycle pulse on misaligned access.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_RSP, WB; encoding 2 bits.
REQ-019 IDLE: on req_valid SHALL latch all req_* fields; aligned -> ISSUE, misaligned (H with addr[0]=1, W with addr[1:0]!=00) -> pulse err_misaligned, stay IDLE, no memory access.
REQ-020 ISSUE: mem_req_valid=1 with latched fields SHALL hold stable until mem_req_ready; on handshake -> WAIT_RSP.
REQ-021 mem_be SHALL be 0001<<addr[1:0] (B), 0011<<addr[1:0] (H), 1111 (W); mem_wdata SHALL replicate byte/half into all lanes.
REQ-022 WAIT_RSP: on mem_rsp_valid, loads SHALL capture extracted/extended data -> WB; stores -> IDLE with no writeback.
REQ-023 Load extraction SHALL select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
REQ-024 WB: wb_valid=1 for exactly one cycle with wb_rd/wb_data, then IDLE; wb_valid SHALL be suppressed when latched rd=0.
REQ-025 Minimum load latency req accept -> wb_valid = 3 cycles with mem_req_ready and mem_rsp_valid each high on first opportunity; store completes in 2.
REQ-026 mem_rsp_valid in IDLE or ISSUE SHALL be ignored; req_valid outside IDLE SHALL be ignored (req_ready=0).
REQ-027 Back-to-back: a new request SHALL be accepted in the IDLE cycle following WB or store completion; no overlap.
REQ-028 wb_data and wb_rd SHALL hold last value between pulses.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE and clear all latched fields and outputs to 0 (req_ready=1 after release).
REQ-030 Reset mid-transaction SHALL abort with no wb_valid; a late mem_rsp_valid after reset SHALL be ignored.

Structure
REQ-031 Shared package SHALL hold funct3 width codes, FSM state encoding, and the byte-enable constants.
REQ-032 Lane extraction/extension SHALL be a combinational sub-module load_align.

Verification
REQ-033 LW addr 0x100, mem_rdata 0x8000_00FF, rd=5 -> mem_be 1111, wb_data 0x8000_00FF, wb_rd 5, wb_valid 3 cycles after accept.
REQ-034 LB addr 0x103, mem_rdata 0x80xx_xxxx -> wb_data 0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-035 SH addr 0x102, wdata 0x1234_ABCD -> mem_be 1100, mem_wdata 0xABCD_ABCD, mem_addr 0x100, no wb_valid.
REQ-036 LW addr 0x101 -> err_misaligned pulse, mem_req_valid never asserted, req_ready stays 1.
REQ-037 mem_req_ready held low 4 cycles -> mem_req_valid/mem_addr stable; rst_n pulsed in WAIT_RSP -> IDLE, no wb_valid, late mem_rsp_valid ignored.
REQ-038 LW to rd=0 -> transaction completes, wb_valid stays 0.
